// File: rtl/placement_pkg.sv
// Shared definitions for the placement read-back engine: defaults, the empty-cell
// marker and the scan FSM state encoding.
package placement_pkg;

   localparam int N_DEFAULT      = 6;
   localparam int DATA_W_DEFAULT = 32;
   localparam int EMPTY_CELL     = -1;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_G_RD  = 4'd1,
      ST_G_WT  = 4'd2,
      ST_G_CHK = 4'd3,
      ST_P_RD  = 4'd4,
      ST_P_WT  = 4'd5,
      ST_P_CHK = 4'd6,
      ST_EMIT  = 4'd7,
      ST_FIN   = 4'd8
   } dump_state_e;

endpackage

// File: rtl/placement_dump_if.sv
// Grid/pos RAM read ports plus the record stream of the placement dump engine.
// master = the dump engine, slave = RAMs and record consumer.
interface placement_dump_if #(
   parameter int DATA_W = placement_pkg::DATA_W_DEFAULT
);
   logic              grid_re;
   logic [DATA_W-1:0] grid_addr;
   logic [DATA_W-1:0] grid_dout;
   logic              posx_re;
   logic              posy_re;
   logic [DATA_W-1:0] pos_addr;
   logic [DATA_W-1:0] posx_dout;
   logic [DATA_W-1:0] posy_dout;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_x;
   logic [DATA_W-1:0] out_y;
   logic [DATA_W-1:0] out_node;
   logic              out_ok;

   modport master (
      output grid_re, grid_addr, posx_re, posy_re, pos_addr,
      output out_valid, out_x, out_y, out_node, out_ok,
      input  grid_dout, posx_dout, posy_dout, out_ready
   );

   modport slave (
      input  grid_re, grid_addr, posx_re, posy_re, pos_addr,
      input  out_valid, out_x, out_y, out_node, out_ok,
      output grid_dout, posx_dout, posy_dout, out_ready
   );
endinterface

// File: rtl/placement_dump_xy_counter.sv
// Row-major cell walker: x/y coordinates plus a running grid address that is
// bumped by one per cell so no multiplier is needed for x*N + y.
module dump_xy_counter #(
   parameter int N      = placement_pkg::N_DEFAULT,
   parameter int DATA_W = placement_pkg::DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              advance,
   output logic [DATA_W-1:0] x,
   output logic [DATA_W-1:0] y,
   output logic [DATA_W-1:0] addr,
   output logic              last_cell
);
   localparam logic [DATA_W-1:0] LAST = DATA_W'(N - 1);
   localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);

   logic [DATA_W-1:0] x_reg;
   logic [DATA_W-1:0] y_reg;
   logic [DATA_W-1:0] addr_reg;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         x_reg    <= '0;
         y_reg    <= '0;
         addr_reg <= '0;
      end else if (advance) begin
         addr_reg <= addr_reg + ONE;
         if (y_reg == LAST) begin
            y_reg <= '0;
            x_reg <= x_reg + ONE;
         end else begin
            y_reg <= y_reg + ONE;
         end
      end
   end

   assign x         = x_reg;
   assign y         = y_reg;
   assign addr      = addr_reg;
   assign last_cell = (x_reg == LAST) && (y_reg == LAST);

endmodule

// File: rtl/placement_dump.sv
// Placement read-back engine: walks the grid row-major, looks up each occupied
// cell's stored position and streams (x, y, node, ok) records with counters.
module placement_dump
   import placement_pkg::*;
#(
   parameter int N      = N_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] occ_cnt,
   output logic [CNT_W-1:0] mismatch_cnt,
   placement_dump_if.master bus
);
   localparam logic [3:0] IDLE  = ST_IDLE;
   localparam logic [3:0] G_RD  = ST_G_RD;
   localparam logic [3:0] G_WT  = ST_G_WT;
   localparam logic [3:0] G_CHK = ST_G_CHK;
   localparam logic [3:0] P_RD  = ST_P_RD;
   localparam logic [3:0] P_WT  = ST_P_WT;
   localparam logic [3:0] P_CHK = ST_P_CHK;
   localparam logic [3:0] EMIT  = ST_EMIT;
   localparam logic [3:0] FIN   = ST_FIN;

   localparam logic signed [DATA_W-1:0] EMPTY = DATA_W'(EMPTY_CELL);

   logic [3:0]        state_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              grid_re_reg;
   logic              pos_re_reg;
   logic              ok_reg;
   logic [DATA_W-1:0] grid_addr_reg;
   logic [DATA_W-1:0] pos_addr_reg;
   logic [DATA_W-1:0] node_reg;
   logic [CNT_W-1:0]  occ_reg;
   logic [CNT_W-1:0]  mis_reg;

   logic [DATA_W-1:0] x;
   logic [DATA_W-1:0] y;
   logic [DATA_W-1:0] cell_addr;
   logic              last_cell;
   logic              start_ok;
   logic              handshake;
   logic              cell_empty;
   logic              cell_bad;
   logic              xy_advance;

   // A start coinciding with the done pulse is dropped; it must be re-issued.
   assign start_ok   = (state_reg == IDLE) && start && !done_reg;
   assign handshake  = (state_reg == EMIT) && bus.out_ready;
   assign cell_empty = ($signed(bus.grid_dout) == EMPTY);
   assign cell_bad   = ($signed(bus.grid_dout) < EMPTY);
   assign xy_advance = !last_cell && (((state_reg == G_CHK) && cell_empty) || handshake);

   dump_xy_counter #(
      .N      (N),
      .DATA_W (DATA_W)
   ) u_xy (
      .clk       (clk),
      .reset     (reset),
      .clear     (start_ok),
      .advance   (xy_advance),
      .x         (x),
      .y         (y),
      .addr      (cell_addr),
      .last_cell (last_cell)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         grid_re_reg   <= 1'b0;
         pos_re_reg    <= 1'b0;
         ok_reg        <= 1'b0;
         grid_addr_reg <= '0;
         pos_addr_reg  <= '0;
         node_reg      <= '0;
         occ_reg       <= '0;
         mis_reg       <= '0;
      end else begin
         grid_re_reg <= 1'b0;
         pos_re_reg  <= 1'b0;
         done_reg    <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start_ok) begin
                  busy_reg  <= 1'b1;
                  occ_reg   <= '0;
                  mis_reg   <= '0;
                  state_reg <= G_RD;
               end
            end
            G_RD: begin
               grid_re_reg   <= 1'b1;
               grid_addr_reg <= cell_addr;
               state_reg     <= G_WT;
            end
            G_WT: state_reg <= G_CHK;
            G_CHK: begin
               if (cell_empty) begin
                  state_reg <= last_cell ? FIN : G_RD;
               end else if (cell_bad) begin
                  // Malformed id: report it without touching the pos RAMs.
                  node_reg  <= bus.grid_dout;
                  ok_reg    <= 1'b0;
                  state_reg <= EMIT;
               end else begin
                  node_reg  <= bus.grid_dout;
                  state_reg <= P_RD;
               end
            end
            P_RD: begin
               pos_re_reg   <= 1'b1;
               pos_addr_reg <= node_reg;
               state_reg    <= P_WT;
            end
            P_WT: state_reg <= P_CHK;
            P_CHK: begin
               ok_reg    <= ($signed(bus.posx_dout) == $signed(x)) &&
                            ($signed(bus.posy_dout) == $signed(y));
               state_reg <= EMIT;
            end
            EMIT: begin
               if (bus.out_ready) begin
                  occ_reg <= occ_reg + CNT_W'(1);
                  if (!ok_reg && (mis_reg != '1)) begin
                     mis_reg <= mis_reg + CNT_W'(1);
                  end
                  state_reg <= last_cell ? FIN : G_RD;
               end
            end
            FIN: begin
               done_reg  <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy          = busy_reg;
   assign done          = done_reg;
   assign occ_cnt       = occ_reg;
   assign mismatch_cnt  = mis_reg;
   assign bus.grid_re   = grid_re_reg;
   assign bus.grid_addr = grid_addr_reg;
   assign bus.posx_re   = pos_re_reg;
   assign bus.posy_re   = pos_re_reg;
   assign bus.pos_addr  = pos_addr_reg;
   assign bus.out_valid = (state_reg == EMIT);
   assign bus.out_x     = x;
   assign bus.out_y     = y;
   assign bus.out_node  = node_reg;
   assign bus.out_ok    = ok_reg;

endmodule

// File: tb/tb_placement_dump.sv
// Randomized bench for placement_dump: RAM models, a stalling consumer and a
// cell-list reference model predicting records, counters and done timing.
module tb_placement_dump;
   import placement_pkg::*;

   localparam int N     = 6;
   localparam int DW    = 32;
   localparam int CW    = 16;
   localparam int CELLS = N * N;
   localparam int NODES = 16;

   typedef struct {
      int x;
      int y;
      int node;
      int ok;
      int stall;
   } rec_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          busy;
   logic          done;
   logic [CW-1:0] occ_cnt;
   logic [CW-1:0] mismatch_cnt;

   placement_dump_if #(.DATA_W(DW)) bus();

   placement_dump #(.N(N), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .occ_cnt      (occ_cnt),
      .mismatch_cnt (mismatch_cnt),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int   grid_mem [CELLS];
   int   stall_mem[CELLS];
   int   posx_mem [NODES];
   int   posy_mem [NODES];
   rec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   grid_reads = 0;
   int   pos_reads = 0;
   bit   fresh = 1'b1;
   int   stall_left = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // RAMs: sample strobe/address at the edge, data held until the next read.
   always @(posedge clk) begin
      if (bus.grid_re)
         bus.grid_dout <= (bus.grid_addr < CELLS) ? grid_mem[bus.grid_addr[5:0]] : 0;
      if (bus.posx_re)
         bus.posx_dout <= (bus.pos_addr < NODES) ? posx_mem[bus.pos_addr[3:0]] : 0;
      if (bus.posy_re)
         bus.posy_dout <= (bus.pos_addr < NODES) ? posy_mem[bus.pos_addr[3:0]] : 0;
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.grid_re) grid_reads++;
         if (bus.posx_re) pos_reads++;
         check("pos_re_pair", bus.posy_re, bus.posx_re);
      end
   end

   // Consumer: holds ready low for the record's stall count, then accepts.
   always @(negedge clk) begin
      if (reset) begin
         bus.out_ready = 1'b0;
      end else if (bus.out_valid) begin
         if (exp_q.size() == 0) begin
            check("rec_unexpected", 1, 0);
            bus.out_ready = 1'b1;
         end else begin
            if (fresh) begin
               stall_left = exp_q[0].stall;
               fresh = 1'b0;
            end
            check("rec_x", longint'($signed(bus.out_x)), exp_q[0].x);
            check("rec_y", longint'($signed(bus.out_y)), exp_q[0].y);
            check("rec_node", longint'($signed(bus.out_node)), exp_q[0].node);
            check("rec_ok", bus.out_ok, exp_q[0].ok);
            if (stall_left > 0) begin
               bus.out_ready = 1'b0;
               stall_left--;
            end else begin
               bus.out_ready = 1'b1;
               $display("record x=%0d y=%0d node=%0d ok=%0d", exp_q[0].x, exp_q[0].y,
                        exp_q[0].node, exp_q[0].ok);
               void'(exp_q.pop_front());
               fresh = 1'b1;
            end
         end
      end else begin
         bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic clear_mem();
      for (int c = 0; c < CELLS; c++) begin
         grid_mem[c]  = -1;
         stall_mem[c] = 0;
      end
      for (int n = 0; n < NODES; n++) begin
         posx_mem[n] = 100 + n;
         posy_mem[n] = 200 + n;
      end
   endtask

   // Expected records plus cycle budget: empty cell 3, malformed id 4,
   // occupied 7, each backpressure cycle +1.
   task automatic build_model(output int s, output int occ, output int mis, output int npos);
      s = 0; occ = 0; mis = 0; npos = 0;
      exp_q.delete();
      for (int x = 0; x < N; x++) begin
         for (int y = 0; y < N; y++) begin
            int v = grid_mem[x * N + y];
            int ok;
            if (v == -1) begin
               s += 3;
            end else begin
               ok = (v >= 0 && posx_mem[v] == x && posy_mem[v] == y) ? 1 : 0;
               s += ((v >= 0) ? 7 : 4) + stall_mem[x * N + y];
               occ++;
               if (ok == 0) mis++;
               if (v >= 0) npos++;
               exp_q.push_back('{x, y, v, ok, stall_mem[x * N + y]});
            end
         end
      end
   endtask

   task automatic run_scan(input string name, input bit poke_busy, input bit poke_done);
      int s, occ, mis, npos, cyc, inj;
      build_model(s, occ, mis, npos);
      fresh = 1'b1;
      grid_reads = 0;
      pos_reads = 0;
      inj = poke_busy ? int'($urandom_range(3, s)) : -1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 3000) begin
         if (cyc == 1) check("busy_after_start", busy, 1);
         if (cyc == 2) check("first_grid_re", bus.grid_re, 1);
         start = (cyc == inj);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check("done_cycle", cyc, s + 2);
      check("busy_at_done", busy, 0);
      check("occ_cnt", occ_cnt, occ);
      check("mismatch_cnt", mismatch_cnt, mis);
      check("records_left", exp_q.size(), 0);
      check("grid_reads", grid_reads, CELLS);
      check("pos_reads", pos_reads, npos);
      start = poke_done;
      @(negedge clk);
      start = 1'b0;
      check("done_single", done, 0);
      check("busy_idle", busy, 0);
      $display("scan %s: records=%0d mismatches=%0d cycles=%0d", name, occ, mis, cyc);
      @(negedge clk);
   endtask

   task automatic reset_mid_scan();
      int seen = 0, n = 0, dn = 0;
      clear_mem();
      grid_mem[4]  = 1; posx_mem[1] = 0; posy_mem[1] = 4;
      grid_mem[20] = 2; posx_mem[2] = 3; posy_mem[2] = 2;
      begin
         int s, occ, mis, npos;
         build_model(s, occ, mis, npos);
      end
      fresh = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (seen < 2 && n < 500) begin
         @(negedge clk);
         n++;
         if (bus.posx_re) seen++;
      end
      check("rst_reach_pwt", seen, 2);
      reset = 1'b1;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_grid_re", bus.grid_re, 0);
      check("rst_pos_re", bus.posx_re | bus.posy_re, 0);
      check("rst_occ", occ_cnt, 0);
      check("rst_mis", mismatch_cnt, 0);
      check("rst_out_x", bus.out_x, 0);
      check("rst_out_node", bus.out_node, 0);
      reset = 1'b0;
      exp_q.delete();
      fresh = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         dn += int'(done) + int'(busy);
      end
      check("rst_no_done", dn, 0);
      $display("reset mid-scan applied");
      run_scan("after_reset", 1'b0, 1'b0);
   endtask

   task automatic random_fill();
      clear_mem();
      for (int c = 0; c < CELLS; c++) begin
         int r = $urandom_range(0, 9);
         int node;
         if (r >= 6) begin
            if (r == 8) begin
               grid_mem[c] = -int'($urandom_range(2, 100));
            end else begin
               node = $urandom_range(0, NODES - 1);
               grid_mem[c] = node;
               if ($urandom_range(0, 1) == 1) begin
                  posx_mem[node] = c / N;
                  posy_mem[node] = c % N;
               end
            end
            stall_mem[c] = $urandom_range(0, 3);
         end
      end
   endtask

   initial begin
      clear_mem();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_valid", bus.out_valid, 0);
      check("reset_grid_re", bus.grid_re, 0);
      check("reset_occ", occ_cnt, 0);
      check("reset_mis", mismatch_cnt, 0);
      reset = 1'b0;
      @(negedge clk);

      clear_mem();
      run_scan("all_empty", 1'b0, 1'b0);

      grid_mem[14] = 3; posx_mem[3] = 2; posy_mem[3] = 2;
      run_scan("node3_ok", 1'b0, 1'b0);

      posy_mem[3] = 4;
      run_scan("node3_bad_y", 1'b0, 1'b0);

      clear_mem();
      grid_mem[35] = 5; posx_mem[5] = 5; posy_mem[5] = 5; stall_mem[35] = 10;
      run_scan("last_cell_stall10", 1'b0, 1'b0);

      clear_mem();
      grid_mem[0] = -7;
      run_scan("malformed_id", 1'b0, 1'b0);

      reset_mid_scan();

      for (int i = 0; i < 8; i++) begin
         random_fill();
         run_scan($sformatf("random%0d", i), (i % 2) == 1, (i % 3) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
